// File: rtl/im_loader.sv
// im_loader: boot-time instruction memory writer.
// Consumes a framed byte stream (16-bit big-endian word count, 4*N data
// bytes MSB first, 8-bit additive checksum), writes each assembled word to the
// instruction RAM from address 0 upward, and releases the CPU only after a
// complete image with a matching checksum has been loaded.
module im_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [3:0]        im_wea,
  output logic [ADDR_W-1:0] im_addra,
  output logic [31:0]       im_dina,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CKSUM  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]        state;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [7:0]        sum;
  logic [23:0]       word;
  logic [1:0]        byte_cnt;
  logic              accept;
  logic [ADDR_W:0]   words_next;
  logic [16:0]       len_rx;

  // Byte handshake: only the byte-consuming states advertise readiness.
  always_comb begin
    rx_ready   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA)   || (state == S_CKSUM);
    accept     = rx_ready && rx_valid;
    words_next = words_loaded + 1'b1;
    len_rx     = {1'b0, len_hi, rx_data};
  end

  // Frame parser, RAM write port and status flags. The write port is loaded
  // on the 4th data byte accept so it is presented exactly during WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len_hi       <= '0;
      len          <= '0;
      sum          <= '0;
      word         <= '0;
      byte_cnt     <= '0;
      im_wea       <= '0;
      im_addra     <= '0;
      im_dina      <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      im_wea <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            sum          <= '0;
            byte_cnt     <= '0;
            state        <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= rx_data;
            sum    <= sum + rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len <= {len_hi, rx_data};
            sum <= sum + rx_data;
            if (len_rx > DEPTH_W) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERR;
            end else if (len_rx == '0) begin
              state <= S_CKSUM;
            end else begin
              byte_cnt <= '0;
              state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            sum      <= sum + rx_data;
            word     <= {word[15:0], rx_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              im_wea   <= 4'b1111;
              im_addra <= words_loaded[ADDR_W-1:0];
              im_dina  <= {word, rx_data};
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          words_loaded <= words_next;
          byte_cnt     <= '0;
          if (32'(words_next) == 32'(len)) state <= S_CKSUM;
          else                             state <= S_DATA;
        end
        S_CKSUM: begin
          if (accept) begin
            busy <= 1'b0;
            if (rx_data == sum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed testbench for im_loader: frames with hand-computed checksums,
// RAM write monitor, and flag/counter checks.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [3:0]  im_wea;
  logic [10:0] im_addra;
  logic [31:0] im_dina;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [10:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_wea[$];
  logic        wr_rdy[$];

  im_loader #(.ADDR_W(11), .DEPTH(2048)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_wea(im_wea), .im_addra(im_addra), .im_dina(im_dina),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Capture every RAM write as the RAM itself would see it.
  always @(posedge clk) begin
    if (im_wea != 4'b0000) begin
      wr_addr.push_back(im_addra);
      wr_data.push_back(im_dina);
      wr_wea.push_back(im_wea);
      wr_rdy.push_back(rx_ready);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_wea.delete(); wr_rdy.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offer one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    for (int unsigned g = 0; g < gap; g++) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int unsigned gap);
    foreach (bytes[i]) send_byte(bytes[i], gap);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_wea"},      32'(im_wea), 32'd0);
    check({tag, "_addra"},    32'(im_addra), 32'd0);
    check({tag, "_dina"},     im_dina, 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_error"},    32'(error), 32'd0);
    check({tag, "_words"},    32'(words_loaded), 32'd0);
    check({tag, "_hold"},     32'(cpu_hold), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    logic [7:0] f3[$];

    f1 = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h10, 8'h3D};
    f2 = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'hAB, 8'hCD,
           8'h00, 8'h00, 8'h00, 8'h00, 8'hB7};
    f3 = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h10, 8'h3E};

    #12;
    check_reset_vals("rst");
    @(negedge clk) reset = 1'b0;

    // Test 1: one word, valid checksum, gaps between bytes.
    clear_log();
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send_frame(f1, 2);
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_words", 32'(words_loaded), 32'd1);
    check("t1_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("t1_addr", 32'(wr_addr[0]), 32'd0);
      check("t1_data", wr_data[0], 32'h24080010);
      check("t1_wea", 32'(wr_wea[0]), 32'hF);
      check("t1_rdy", 32'(wr_rdy[0]), 32'd0);
    end

    // Test 2: two words, rx_valid effectively held high, start pulsed mid-load.
    repeat (3) @(negedge clk);
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(f2[i], 0);
    pulse_start();
    check("t2_mid_busy", 32'(busy), 32'd1);
    for (int i = 4; i < 11; i++) send_byte(f2[i], 0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_error", 32'(error), 32'd0);
    check("t2_words", 32'(words_loaded), 32'd2);
    check("t2_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t2_addr0", 32'(wr_addr[0]), 32'd0);
      check("t2_data0", wr_data[0], 32'h3C01ABCD);
      check("t2_rdy0", 32'(wr_rdy[0]), 32'd0);
      check("t2_addr1", 32'(wr_addr[1]), 32'd1);
      check("t2_data1", wr_data[1], 32'h00000000);
      check("t2_rdy1", 32'(wr_rdy[1]), 32'd0);
    end
    @(negedge clk);
    check("t2_flags_persist", 32'(done), 32'd1);

    // Test 3: bad checksum.
    repeat (2) @(negedge clk);
    clear_log();
    pulse_start();
    check("t3_done_cleared", 32'(done), 32'd0);
    send_frame(f3, 1);
    check("t3_error", 32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_nwr", 32'(wr_addr.size()), 32'd1);

    // Test 4: length above DEPTH.
    repeat (2) @(negedge clk);
    clear_log();
    pulse_start();
    send_byte(8'h08, 0);
    send_byte(8'h01, 0);
    check("t4_error", 32'(error), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_hold", 32'(cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    check("t4_rx_ready", 32'(rx_ready), 32'd0);
    check("t4_nwr", 32'(wr_addr.size()), 32'd0);

    // Test 5: empty image.
    clear_log();
    pulse_start();
    check("t5_error_cleared", 32'(error), 32'd0);
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    check("t5_words", 32'(words_loaded), 32'd0);
    check("t5_nwr", 32'(wr_addr.size()), 32'd0);

    // Test 6: reset mid-load, then a clean reload.
    repeat (2) @(negedge clk);
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(f1[i], 0);
    reset = 1'b1;
    #1;
    check_reset_vals("t6");
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_nwr_abort", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    send_frame(f1, 0);
    check("t6_done", 32'(done), 32'd1);
    check("t6_words", 32'(words_loaded), 32'd1);
    check("t6_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) check("t6_data", wr_data[0], 32'h24080010);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
